// File: rtl/calc_seq_ctrl_pkg.sv
// calc_seq_pkg: shared states, mode/size codes and size helpers for calc_seq_ctrl.
package calc_seq_pkg;
    typedef enum logic [2:0] {
        SEL_MODE = 3'd0, SEL_SIZE = 3'd1, LOAD_A = 3'd2, LOAD_B = 3'd3, EXEC = 3'd4, DONE = 3'd5
    } state_t;
    typedef enum logic [2:0] {
        M_ADD, M_SUB, M_SHL, M_SHR, M_AND, M_OR, M_STORE, M_FETCH
    } mode_t;
    localparam logic [1:0] SZ_16 = 2'b00, SZ_32 = 2'b01, SZ_64 = 2'b10;
    function automatic logic [6:0] size_to_width(input logic [1:0] sz);
        return sz == SZ_16 ? 7'd16 : sz == SZ_32 ? 7'd32 : sz == SZ_64 ? 7'd64 : 7'd0;
    endfunction
    function automatic logic [63:0] mask(input logic [1:0] sz);
        return sz == SZ_16 ? 64'hFFFF : sz == SZ_32 ? 64'hFFFF_FFFF : '1;
    endfunction
endpackage

// File: rtl/calc_seq_ctrl_if.sv
// calc_seq_ctrl_if: switch/button inputs and result/status outputs of the calculator.
interface calc_seq_ctrl_if #(parameter int MAX_WIDTH = 64);
    logic [MAX_WIDTH-1:0] sw, out;
    logic btn, sign, carry, done, err;
    logic [2:0] state_o;
    modport master (output sw, btn, input out, sign, carry, done, err, state_o);
    modport slave (input sw, btn, output out, sign, carry, done, err, state_o);
endinterface

// File: rtl/calc_seq_ctrl_btn_edge.sv
// calc_btn_edge: 2-flop sync and rising-edge press pulse; CALC_SEQ_DEBOUNCE_EN adds a stability counter.
module calc_btn_edge #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
`ifdef CALC_SEQ_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif
    logic s1, s2, s3;
    always_ff @(posedge clk or negedge rst)
        if (!rst) {s1, s2} <= '0;
        else {s1, s2} <= {btn, s1};
    if (DEB_EN) begin : g_deb
        localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
        logic [CW-1:0] cnt;
        // s3 is the accepted level; it follows s2 only after an unbroken run of differing cycles
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                cnt   <= '0;
                s3    <= 1'b0;
                press <= 1'b0;
            end else begin
                press <= 1'b0;
                if (s2 == s3) cnt <= '0;
                else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt   <= '0;
                    s3    <= s2;
                    press <= s2;
                end else cnt <= cnt + 1'b1;
            end
    end else begin : g_raw
        always_ff @(posedge clk or negedge rst)
            if (!rst) s3 <= 1'b0;
            else s3 <= s2;
        assign press = s2 & ~s3;
    end
endmodule

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: button-sequenced calculator controller with operand store.
// Define CALC_SEQ_DEBOUNCE_EN to debounce btn for DEBOUNCE_CYCLES cycles.
module calc_seq_ctrl
    import calc_seq_pkg::*;
#(
    parameter int MAX_WIDTH       = 64,
    parameter int STORE_DEPTH     = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic clk,
    input logic rst,
    calc_seq_ctrl_if.slave bus
);
    localparam int AW = $clog2(STORE_DEPTH);
    state_t state, state_nx;
    mode_t mode;
    logic [1:0] size;
    logic [63:0] a, b, sw64, msk, addr, a_se, shr, raw, res, res_q;
    logic [63:0] store_q [STORE_DEPTH];
    logic [64:0] sum, dif;
    logic [6:0] w, sz_w;
    logic [5:0] msb, amt;
    logic [AW-1:0] idx;
    logic press, size_ok, mem_bad, res_carry, sign_q, carry_q, err_q;
    calc_btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk(clk), .rst(rst), .btn(bus.btn), .press(press)
    );
    assign sw64    = 64'(bus.sw);
    assign sz_w    = size_to_width(bus.sw[1:0]);
    assign size_ok = sz_w != 7'd0 && int'(sz_w) <= MAX_WIDTH;
    assign w       = size_to_width(size);
    assign msk     = mask(size);
    assign msb     = 6'(w - 7'd1);
    assign amt     = b[5:0] & msb;
    assign sum     = {1'b0, a} + {1'b0, b};
    assign dif     = {1'b0, a} - {1'b0, b};
    // sign-extend A from the selected size so >>> replicates bit size-1
    assign a_se    = a[msb] ? (a | ~msk) : a;
    assign shr     = $signed(a_se) >>> amt;
    assign addr    = mode == M_FETCH ? a : b;
    assign idx     = addr[AW-1:0];
    assign mem_bad = (mode == M_STORE || mode == M_FETCH) && addr >= 64'(STORE_DEPTH);
    always_comb begin
        raw = mode == M_ADD ? sum[63:0] : mode == M_SUB ? dif[63:0] : mode == M_SHL ? a << amt :
              mode == M_SHR ? shr : mode == M_AND ? (a & b) : mode == M_OR ? (a | b) :
              mode == M_STORE ? a : store_q[idx];
        res = mem_bad ? '0 : raw & msk;
        res_carry = mode == M_ADD ? sum[w] : mode == M_SUB ? dif[64] : 1'b0;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= SEL_MODE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            SEL_MODE: if (press) state_nx = SEL_SIZE;
            SEL_SIZE: if (press) state_nx = size_ok ? LOAD_A : SEL_MODE;
            LOAD_A:   if (press) state_nx = mode == M_FETCH ? EXEC : LOAD_B;
            LOAD_B:   if (press) state_nx = EXEC;
            EXEC:     state_nx = DONE;
            DONE:     if (press) state_nx = SEL_MODE;
            default:  state_nx = SEL_MODE;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            mode    <= M_ADD;
            size    <= SZ_16;
            a       <= '0;
            b       <= '0;
            res_q   <= '0;
            sign_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < STORE_DEPTH; i++) store_q[i] <= '0;
        end else begin
            err_q <= (state == SEL_SIZE && press && !size_ok) || (state == EXEC && mem_bad);
            if (press && state == SEL_MODE) mode <= mode_t'(bus.sw[2:0]);
            if (press && state == SEL_SIZE) size <= bus.sw[1:0];
            if (press && state == LOAD_A) a <= sw64 & msk;
            if (press && state == LOAD_B) b <= sw64 & msk;
            if (state == EXEC) begin
                res_q   <= res;
                sign_q  <= res[msb];
                carry_q <= mem_bad ? 1'b0 : res_carry;
                if (mode == M_STORE && !mem_bad) store_q[idx] <= a;
            end
        end
    assign bus.out     = MAX_WIDTH'(res_q);
    assign bus.sign    = sign_q;
    assign bus.carry   = carry_q;
    assign bus.done    = state == DONE;
    assign bus.err     = err_q;
    assign bus.state_o = state;
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: directed scoreboard bench for calc_seq_ctrl.
module tb_calc_seq_ctrl;
    typedef struct {
        logic [63:0] out;
        logic sign, carry;
    } exp_t;
    logic clk = 1'b0, rst = 1'b0;
    int errors = 0, checks = 0, err_seen = 0, err0;
    exp_t sb[$];
    always #5 clk = ~clk;
    calc_seq_ctrl_if #(.MAX_WIDTH(64)) bus ();
    calc_seq_ctrl #(.MAX_WIDTH(64), .STORE_DEPTH(8), .DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always @(negedge clk) if (bus.err === 1'b1) err_seen++;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic push(input logic [63:0] v);
        @(negedge clk);
        bus.sw  = v;
        bus.btn = 1'b1;
        repeat (24) @(negedge clk);
        bus.btn = 1'b0;
        repeat (24) @(negedge clk);
    endtask
    task automatic collect(input string tag);
        exp_t e;
        int n = 0;
        while (bus.done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        e = sb.pop_front();
        chk({tag, "_out"}, bus.out, e.out);
        chk({tag, "_sign"}, 64'(bus.sign), 64'(e.sign));
        chk({tag, "_carry"}, 64'(bus.carry), 64'(e.carry));
        push(64'd0);
        chk({tag, "_ack_state"}, 64'(bus.state_o), 64'd0);
        chk({tag, "_ack_out_held"}, bus.out, e.out);
    endtask
    task automatic op(input string tag, input logic [2:0] m, input logic [1:0] sz,
                      input logic [63:0] av, input logic [63:0] bv,
                      input logic [63:0] eo, input logic es, input logic ec);
        sb.push_back('{eo, es, ec});
        push(64'(m));
        push(64'(sz));
        push(av);
        if (m != 3'b111) push(bv);
        collect(tag);
    endtask
    initial begin
        bus.sw  = '0;
        bus.btn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out", bus.out, 64'd0);
        chk("rst_flags", {59'd0, bus.sign, bus.carry, bus.done, bus.err}, 64'd0);
        chk("rst_state", 64'(bus.state_o), 64'd0);
        rst = 1'b1;
        op("add16", 3'b000, 2'b00, 64'hFFFF, 64'h0001, 64'h0, 1'b0, 1'b1);
        op("sub16", 3'b001, 2'b00, 64'h0001, 64'h0002, 64'hFFFF, 1'b1, 1'b1);
        op("shl16", 3'b010, 2'b00, 64'h8001, 64'd17, 64'h0002, 1'b0, 1'b0);
        op("shr32", 3'b011, 2'b01, 64'h8000_0000, 64'd36, 64'hF800_0000, 1'b1, 1'b0);
        op("shr16pos", 3'b011, 2'b00, 64'h4000, 64'd1, 64'h2000, 1'b0, 1'b0);
        op("and64", 3'b100, 2'b10, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
           64'hF000_F000_F000_F000, 1'b1, 1'b0);
        op("or32", 3'b101, 2'b01, 64'hFFFF_FFFF_1234_0000, 64'h0000_5678,
           64'h1234_5678, 1'b0, 1'b0);
        op("add64", 3'b000, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1'b0, 1'b1);
        op("store64", 3'b110, 2'b10, 64'hDEAD_BEEF_0123_4567, 64'd3,
           64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0);
        op("fetch16", 3'b111, 2'b00, 64'd3, 64'd0, 64'h4567, 1'b0, 1'b0);
        err0 = err_seen;
        push(64'd0);
        push(64'd3);
        chk("badsize_err_cycles", 64'(err_seen - err0), 64'd1);
        chk("badsize_state", 64'(bus.state_o), 64'd0);
        err0 = err_seen;
        op("store_bad", 3'b110, 2'b00, 64'h1234, 64'd8, 64'd0, 1'b0, 1'b0);
        chk("store_bad_err_cycles", 64'(err_seen - err0), 64'd1);
        op("fetch64_kept", 3'b111, 2'b10, 64'd3, 64'd0, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0);
        op("fetch_empty", 3'b111, 2'b10, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        op("store_e5", 3'b110, 2'b01, 64'hCAFE_F00D, 64'd5, 64'hCAFE_F00D, 1'b1, 1'b0);
        push(64'd0);
        push(64'd0);
        push(64'h1);
        chk("pre_rst_state", 64'(bus.state_o), 64'd3);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("midrst_out", bus.out, 64'd0);
        chk("midrst_flags", {59'd0, bus.sign, bus.carry, bus.done, bus.err}, 64'd0);
        chk("midrst_state", 64'(bus.state_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        op("fetch_after_rst", 3'b111, 2'b01, 64'd5, 64'd0, 64'd0, 1'b0, 1'b0);
        @(negedge clk);
        bus.sw  = '0;
        bus.btn = 1'b1;
        repeat (100) @(negedge clk);
        bus.btn = 1'b0;
        repeat (24) @(negedge clk);
        chk("held_btn_state", 64'(bus.state_o), 64'd1);
`ifdef CALC_SEQ_DEBOUNCE_EN
        bus.btn = 1'b1;
        repeat (5) @(negedge clk);
        bus.btn = 1'b0;
        repeat (30) @(negedge clk);
        chk("glitch_state", 64'(bus.state_o), 64'd1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
